alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port a  input  WIDTH  operand A.
REQ-005 SHALL have port b  input  WIDTH  operand B.
REQ-006 SHALL have port cmd  input  4  command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL, 9-15 reserved.
REQ-007 SHALL have port in_valid  input  1  a/b/cmd valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a command this cycle.
REQ-009 SHALL have port res  output  WIDTH  registered result.
REQ-010 SHALL have ports cout, ofl, zero  output  1 each  registered carry-out, signed overflow, result-is-zero flags.
REQ-011 SHALL have port out_valid  output  1  res/flags valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-013 SHALL accept a command on a rising edge where in_valid and in_ready are both 1, capturing a, b, cmd.
REQ-014 SHALL implement states IDLE, MUL_BUSY; in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1).
REQ-015 SHALL, for cmd 0-7 and 9-15, assert out_valid with the result one cycle after acceptance (latency 1, throughput 1/cycle under out_ready = 1).
REQ-016 SHALL, for MUL, enter MUL_BUSY for exactly WIDTH cycles of shift-add (one bit of b per cycle), then return to IDLE with out_valid = 1 the cycle MUL_BUSY ends; latency WIDTH + 1 from acceptance.
REQ-017 SHALL hold res, flags and out_valid stable while out_valid = 1 and out_ready = 0; a result is consumed on an edge where out_valid and out_ready are both 1.
REQ-018 SHALL, on consumption without a simultaneous acceptance, clear out_valid; consumption and acceptance in the same cycle SHALL replace the result with no bubble.
REQ-019 ADD: res = (a + b) mod 2^WIDTH; cout = carry out of MSB; ofl = 1 when a, b share sign and res sign differs.
REQ-020 SUB: computed as a + ~b + 1; cout = carry out of MSB (1 = no borrow); ofl = 1 when a, b differ in sign and res sign differs from a.
REQ-021 SLT: res = 1 when a < b signed (sign of a-b XOR ofl of a-b), else 0; cout = ofl = 0.
REQ-022 XOR/AND/NAND/NOR/OR: bitwise over WIDTH; cout = ofl = 0.
REQ-023 MUL: res = low WIDTH bits of unsigned a*b; ofl = 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero; cout = 0.
REQ-024 Reserved cmd: res = 0, cout = ofl = 0, zero = 1.
REQ-025 zero SHALL equal 1 exactly when res == 0, for every command.
REQ-026 SHALL ignore a, b, cmd, in_valid while in_ready = 0.

Reset
REQ-027 SHALL, on reset_n low, immediately force state = IDLE, out_valid = 0, res = 0, cout = 0, ofl = 0, zero = 0, in_ready = 0 while reset_n low.
REQ-028 SHALL abandon any MUL in progress on reset; no result from it is ever presented.
REQ-029 SHALL drive in_ready = 1 from the first edge after reset_n returns high.

Verification
REQ-030 WIDTH=32, ADD a=72738 b=-125 (0xFFFFFF83) -> one cycle later res=0x00011BA5, cout=1, ofl=0, zero=0.
REQ-031 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> res=0x80000000, cout=0, ofl=1; SUB a=2 b=1 -> res=1, cout=1, ofl=0; ADD 0+0 -> res=0, zero=1.
REQ-032 WIDTH=32, SLT a=-1 b=1 -> res=1; SLT a=1 b=-1 -> res=0; NAND a=0 b=0 -> res=0xFFFFFFFF.
REQ-033 WIDTH=32, MUL a=6 b=7 -> in_ready=0 for 32 cycles, out_valid at cycle 33 with res=42, ofl=0; MUL a=0x10000 b=0x10000 -> res=0, ofl=1, zero=1.
REQ-034 out_ready=0 for 5 cycles after an ADD result -> res/flags/out_valid unchanged, in_ready=0; out_ready=1 with new in_valid -> next result appears next cycle, no bubble.
REQ-035 reset_n pulsed low at cycle 10 of a MUL -> out_valid=0, res=0 immediately; no stale result after release; WIDTH=8 rerun of REQ-030/033 at 8-bit wraps correctly (0x7F+1 -> 0x80, ofl=1).

Source files
------------

// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle arithmetic/logic ops plus a WIDTH-step shift-add multiplier,
// with a one-entry valid/ready result register.
//
// state    | meaning
// IDLE     | accepts a command whenever the result slot is empty or being drained
// MUL_BUSY | one shift-add step per cycle; result is written on the last step
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ofl,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_NOR  = 4'd6;
  localparam logic [3:0] CMD_OR   = 4'd7;
  localparam logic [3:0] CMD_MUL  = 4'd8;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state, state_nxt;
  logic             run_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic             accept, consume, mul_last;
  logic [WIDTH:0]   add_s, sub_s, step_s;
  logic             add_ofl, sub_ofl;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ofl;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

  // run_q keeps in_ready low until the first edge after reset release
  assign in_ready = run_q && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign mul_last = (state == MUL_BUSY) && (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && (cmd == CMD_MUL)) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_last) state_nxt = IDLE;
    endcase
  end

  assign add_s   = {1'b0, a} + {1'b0, b};
  assign sub_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ofl  = 1'b0;
    case (cmd)
      CMD_ADD: begin
        alu_res  = add_s[WIDTH-1:0];
        alu_cout = add_s[WIDTH];
        alu_ofl  = add_ofl;
      end
      CMD_SUB: begin
        alu_res  = sub_s[WIDTH-1:0];
        alu_cout = sub_s[WIDTH];
        alu_ofl  = sub_ofl;
      end
      CMD_XOR:  alu_res = a ^ b;
      CMD_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_ofl};
      CMD_AND:  alu_res = a & b;
      CMD_NAND: alu_res = ~(a & b);
      CMD_NOR:  alu_res = ~(a | b);
      CMD_OR:   alu_res = a | b;
      default:  alu_res = '0;
    endcase
  end

  // {acc_hi, acc_lo} is the running product; acc_lo starts as b and shifts out one bit per step
  assign step_s     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = step_s[WIDTH:1];
  assign mul_lo_nxt = {step_s[0], acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      res       <= '0;
      cout      <= 1'b0;
      ofl       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept && (cmd == CMD_MUL)) begin
        mcand     <= a;
        acc_hi    <= '0;
        acc_lo    <= b;
        cnt       <= CNT_LOAD;
        out_valid <= 1'b0;
      end else if (accept) begin
        res       <= alu_res;
        cout      <= alu_cout;
        ofl       <= alu_ofl;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if (state == MUL_BUSY) begin
        acc_hi <= mul_hi_nxt;
        acc_lo <= mul_lo_nxt;
        cnt    <= cnt - CNT_ONE;
        if (mul_last) begin
          res       <= mul_lo_nxt;
          cout      <= 1'b0;
          ofl       <= |mul_hi_nxt;
          zero      <= (mul_lo_nxt == '0);
          out_valid <= 1'b1;
        end
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
